kpn_split_controller: RTL and testbench

Sequences one KPN split node: accepts a token from the input channel and delivers a copy to two output channels.
- Uses valid/ready handshakes on all channels, giving blocking-write Kahn semantics.
- A token retires only after both consumers have taken it.
- Sits between an upstream FIFO and two downstream FIFOs. It replaces a free-running combinational split with a flow-controlled one.

---
 rtl/kpn_split_controller_if.sv | 28 ++
 rtl/kpn_split_controller.sv | 121 ++++++++++++
 tb/tb_kpn_split_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/kpn_split_controller_if.sv
// kpn_split_controller_if: channel bundle for one KPN split node.
// Carries the input channel and both output channels, each with a
// valid/ready handshake.
// The master modport is the controller's view. The slave modport is the
// environment's view, covering the upstream FIFO and both consumers.
interface kpn_split_controller_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out1_data;
  logic              out1_valid;
  logic              out1_ready;
  logic [DATA_W-1:0] out2_data;
  logic              out2_valid;
  logic              out2_ready;

  modport master (
    input  in_data, in_valid, out1_ready, out2_ready,
    output in_ready, out1_data, out1_valid, out2_data, out2_valid
  );

  modport slave (
    output in_data, in_valid, out1_ready, out2_ready,
    input  in_ready, out1_data, out1_valid, out2_data, out2_valid
  );
endinterface

// File: rtl/kpn_split_controller.sv
// kpn_split_controller: flow-controlled split for one KPN node.
// The controller accepts one token from the input channel and offers a copy
// on each of the two output channels. The token retires only after both
// consumers have taken it, which gives blocking-write Kahn semantics.
// The optional macro SPLIT_TOKEN_STATS_EN builds a saturating counter of
// retired tokens. When the macro is undefined, tok_count_o is tied to zero.
module kpn_split_controller #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  kpn_split_controller_if.master bus,
  output logic                   busy_o,
  output logic                   token_done_o,
  output logic [CNT_W-1:0]       tok_count_o
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_DELIVER = 1'b1
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] hold_q;
  logic              pend1_q;
  logic              pend2_q;
  logic              busy_q;
  logic              token_done_q;

  logic              pend1_d;
  logic              pend2_d;
  logic              accept_s;
  logic              retire_s;

  // Compute the next pending bits and detect the accept and retire events.
  always_comb begin
    pend1_d  = pend1_q && !bus.out1_ready;
    pend2_d  = pend2_q && !bus.out2_ready;
    accept_s = (state_q == ST_IDLE) && bus.in_valid;
    if (state_q == ST_DELIVER) begin
      retire_s = !pend1_d && !pend2_d;
    end else begin
      retire_s = 1'b0;
    end
  end

  // Handle the split sequencing FSM and all of its registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      hold_q       <= {DATA_W{1'b0}};
      pend1_q      <= 1'b0;
      pend2_q      <= 1'b0;
      busy_q       <= 1'b0;
      token_done_q <= 1'b0;
    end else begin
      token_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            hold_q  <= bus.in_data;
            pend1_q <= 1'b1;
            pend2_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_DELIVER;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DELIVER: begin
          // Each copy clears independently; the token retires when the last one goes.
          pend1_q <= pend1_d;
          pend2_q <= pend2_d;
          if (retire_s) begin
            busy_q       <= 1'b0;
            token_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end else begin
            state_q <= ST_DELIVER;
          end
        end
        default: begin
          pend1_q <= 1'b0;
          pend2_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // in_ready is the one combinational output: it must drop while reset is high.
  assign bus.in_ready   = (state_q == ST_IDLE) && !reset_i;
  assign bus.out1_valid = pend1_q;
  assign bus.out2_valid = pend2_q;
  assign bus.out1_data  = hold_q;
  assign bus.out2_data  = hold_q;
  assign busy_o         = busy_q;
  assign token_done_o   = token_done_q;

`ifdef SPLIT_TOKEN_STATS_EN
  logic [CNT_W-1:0] tok_count_q;

  // Count retired tokens and saturate at the all-ones value.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tok_count_q <= {CNT_W{1'b0}};
    end else if (retire_s && (tok_count_q != {CNT_W{1'b1}})) begin
      tok_count_q <= tok_count_q + CNT_W'(1);
    end else begin
      tok_count_q <= tok_count_q;
    end
  end

  assign tok_count_o = tok_count_q;
`else
  assign tok_count_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_kpn_split_controller.sv
// tb_kpn_split_controller: scoreboard bench for the KPN split controller.
// The reference model keeps one queue of undelivered copies per output.
// Accepted tokens are pushed onto both queues, and each transfer pops its queue.
// On the falling edge a monitor compares every DUT output with the state the
// model implies.
module tb_kpn_split_controller;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             busy;
  logic             token_done;
  logic [CNT_W-1:0] tok_count;

  kpn_split_controller_if #(.DATA_W(DATA_W)) bus_if ();

  kpn_split_controller #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .bus          (bus_if),
    .busy_o       (busy),
    .token_done_o (token_done),
    .tok_count_o  (tok_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [DATA_W-1:0] q1[$];
  logic [DATA_W-1:0] q2[$];
  logic [DATA_W-1:0] last_data = '0;
  logic              exp_done  = 1'b0;
  int                exp_cnt   = 0;
  bit                started   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: update the scoreboard at each rising edge from the sampled inputs.
  initial begin
    bit was_busy;
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (reset) begin
        q1.delete();
        q2.delete();
        last_data = '0;
        exp_done  = 1'b0;
        exp_cnt   = 0;
      end else begin
        exp_done = 1'b0;
        was_busy = (q1.size() != 0) || (q2.size() != 0);
        if (q1.size() != 0 && bus_if.out1_ready) void'(q1.pop_front());
        if (q2.size() != 0 && bus_if.out2_ready) void'(q2.pop_front());
        if (was_busy) begin
          if (q1.size() == 0 && q2.size() == 0) begin
            exp_done = 1'b1;
            if (exp_cnt < CNT_MAX) exp_cnt++;
          end
        end else if (bus_if.in_valid) begin
          q1.push_back(bus_if.in_data);
          q2.push_back(bus_if.in_data);
          last_data = bus_if.in_data;
        end
      end
    end
  end

  // Monitor: on each falling edge compare DUT outputs with the model.
  initial begin
    logic [DATA_W-1:0] e1;
    logic [DATA_W-1:0] e2;
    forever begin
      @(negedge clk);
      if (started) begin
        e1 = (q1.size() != 0) ? q1[0] : last_data;
        e2 = (q2.size() != 0) ? q2[0] : last_data;
        chk("in_ready", 32'(bus_if.in_ready), 32'(!reset && q1.size() == 0 && q2.size() == 0));
        chk("out1_valid", 32'(bus_if.out1_valid), 32'(q1.size() != 0));
        chk("out2_valid", 32'(bus_if.out2_valid), 32'(q2.size() != 0));
        chk("out1_data", 32'(bus_if.out1_data), 32'(e1));
        chk("out2_data", 32'(bus_if.out2_data), 32'(e2));
        chk("busy", 32'(busy), 32'(q1.size() != 0 || q2.size() != 0));
        chk("token_done", 32'(token_done), 32'(exp_done));
`ifdef SPLIT_TOKEN_STATS_EN
        chk("tok_count", 32'(tok_count), 32'(exp_cnt));
`else
        chk("tok_count", 32'(tok_count), 32'd0);
`endif
      end
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    reset             = 1'b1;
    bus_if.in_valid   = 1'b1;
    bus_if.in_data    = 16'hFFFF;
    bus_if.out1_ready = 1'b0;
    bus_if.out2_ready = 1'b0;
    step(2);
    reset           = 1'b0;
    bus_if.in_valid = 1'b0;
    step(1);

    // Single token with both consumers ready.
    bus_if.out1_ready = 1'b1;
    bus_if.out2_ready = 1'b1;
    bus_if.in_valid   = 1'b1;
    bus_if.in_data    = 16'h1234;
    step(1);
    bus_if.in_valid = 1'b0;
    step(3);

    // Consumer 2 stalls for 5 cycles while upstream waits with 0x5555.
    bus_if.out1_ready = 1'b1;
    bus_if.out2_ready = 1'b0;
    bus_if.in_valid   = 1'b1;
    bus_if.in_data    = 16'hBEEF;
    step(1);
    bus_if.in_data = 16'h5555;
    step(5);
    bus_if.out2_ready = 1'b1;
    step(2);
    bus_if.in_valid = 1'b0;
    step(3);

    // Reset one cycle into DELIVER.
    bus_if.out1_ready = 1'b0;
    bus_if.out2_ready = 1'b0;
    bus_if.in_valid   = 1'b1;
    bus_if.in_data    = 16'hA5A5;
    step(1);
    bus_if.in_valid = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);

    // Back-to-back tokens 1..4, then 5 more to reach counter saturation.
    bus_if.out1_ready = 1'b1;
    bus_if.out2_ready = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = 16'(t);
      step(2);
    end
    bus_if.in_valid = 1'b0;
    step(3);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      bus_if.in_valid   = 1'($urandom_range(0, 1));
      bus_if.in_data    = 16'($urandom);
      bus_if.out1_ready = ($urandom_range(0, 3) != 0);
      bus_if.out2_ready = ($urandom_range(0, 2) != 0);
      reset             = ($urandom_range(0, 79) == 0);
      step(1);
    end
    reset = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
